// File: rtl/avst_pkt_arbiter.sv
// avst_pkt_arbiter
//   Packet-granular arbiter that shares one Avalon-ST video output between two
//   Avalon-ST sources. Ownership is granted per packet and a packet is never
//   split. Every output beat is tagged with the channel it came from. The output
//   stage is a register, so it can drive downstream video IP directly.
//
// Ports
//   clk_clk, reset_reset            clock, asynchronous active-high reset
//   arb_in{0,1}_data/valid/sop/eop  source beats
//   arb_in{0,1}_ready               beat accepted when valid & ready
//   arb_out_data/valid/sop/eop      registered output beat
//   arb_out_channel                 source index of the output beat
//   arb_out_ready                   downstream ready
//   cfg_prio_mode                   0 = round-robin, 1 = fixed priority (ch0 wins)
//   cfg_force_en, cfg_force_ch      restrict grants to one channel
//   cfg_clr                         one-cycle pulse: clears counters and sop_err
//   stat_busy                       a packet is in progress
//   stat_grant                      channel of the current/last grant
//   stat_pkt_cnt0/1                 completed packets per channel (wrapping)
//   stat_sop_err                    sticky: SOP accepted on a non-first beat
module avst_pkt_arbiter #(
  parameter int DATA_W = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] arb_in0_data,
  input  logic              arb_in0_valid,
  input  logic              arb_in0_startofpacket,
  input  logic              arb_in0_endofpacket,
  output logic              arb_in0_ready,
  input  logic [DATA_W-1:0] arb_in1_data,
  input  logic              arb_in1_valid,
  input  logic              arb_in1_startofpacket,
  input  logic              arb_in1_endofpacket,
  output logic              arb_in1_ready,
  output logic [DATA_W-1:0] arb_out_data,
  output logic              arb_out_valid,
  output logic              arb_out_startofpacket,
  output logic              arb_out_endofpacket,
  output logic              arb_out_channel,
  input  logic              arb_out_ready,
  input  logic              cfg_prio_mode,
  input  logic              cfg_force_en,
  input  logic              cfg_force_ch,
  input  logic              cfg_clr,
  output logic              stat_busy,
  output logic              stat_grant,
  output logic [CNT_W-1:0]  stat_pkt_cnt0,
  output logic [CNT_W-1:0]  stat_pkt_cnt1,
  output logic              stat_sop_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT0 = 2'd1,
    PKT1 = 2'd2
  } state_t;

  state_t state_r;
  logic   last_ch_r;   // channel that completed the most recent packet
  logic   first_r;     // next accepted beat opens the packet

  logic              load_s;
  logic              sel_ch_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_sop_s;
  logic              sel_eop_s;
  logic              acc_s;
  logic              elig0_s;
  logic              elig1_s;
  logic              grant_req_s;
  logic              grant_ch_s;

  // Output register can take a new beat when empty or being drained this cycle.
  assign load_s = !arb_out_valid | arb_out_ready;

  // Input ready, beat mux and accept strobe for the channel owning the packet.
  always_comb begin
    arb_in0_ready = 1'b0;
    arb_in1_ready = 1'b0;
    sel_ch_s      = 1'b0;
    sel_data_s    = arb_in0_data;
    sel_sop_s     = arb_in0_startofpacket;
    sel_eop_s     = arb_in0_endofpacket;
    acc_s         = 1'b0;
    case (state_r)
      PKT0: begin
        arb_in0_ready = load_s;
        acc_s         = arb_in0_valid & load_s;
      end
      PKT1: begin
        arb_in1_ready = load_s;
        sel_ch_s      = 1'b1;
        sel_data_s    = arb_in1_data;
        sel_sop_s     = arb_in1_startofpacket;
        sel_eop_s     = arb_in1_endofpacket;
        acc_s         = arb_in1_valid & load_s;
      end
      default: begin
        arb_in0_ready = 1'b0;
        arb_in1_ready = 1'b0;
      end
    endcase
  end

  // Grant decision evaluated in IDLE; the force setting masks eligibility first.
  always_comb begin
    elig0_s     = arb_in0_valid & (!cfg_force_en | (cfg_force_ch == 1'b0));
    elig1_s     = arb_in1_valid & (!cfg_force_en | (cfg_force_ch == 1'b1));
    grant_req_s = elig0_s | elig1_s;
    grant_ch_s  = 1'b0;
    if (elig0_s && elig1_s) begin
      grant_ch_s = cfg_prio_mode ? 1'b0 : ~last_ch_r;
    end else if (elig1_s) begin
      grant_ch_s = 1'b1;
    end else begin
      grant_ch_s = 1'b0;
    end
  end

  // Packet FSM plus the status registers it owns.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_r       <= IDLE;
      last_ch_r     <= 1'b1;
      first_r       <= 1'b1;
      stat_busy     <= 1'b0;
      stat_grant    <= 1'b0;
      stat_pkt_cnt0 <= '0;
      stat_pkt_cnt1 <= '0;
      stat_sop_err  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_req_s) begin
            state_r    <= grant_ch_s ? PKT1 : PKT0;
            stat_grant <= grant_ch_s;
            stat_busy  <= 1'b1;
            first_r    <= 1'b1;
          end
        end
        PKT0, PKT1: begin
          if (acc_s) begin
            first_r <= 1'b0;
            if (sel_eop_s) begin
              state_r   <= IDLE;
              stat_busy <= 1'b0;
              last_ch_r <= sel_ch_s;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          stat_busy <= 1'b0;
        end
      endcase

      // A clear in the same cycle as a packet completion leaves the counter at 0.
      if (cfg_clr) begin
        stat_pkt_cnt0 <= '0;
        stat_pkt_cnt1 <= '0;
        stat_sop_err  <= 1'b0;
      end else begin
        if (acc_s && sel_eop_s && !sel_ch_s) begin
          stat_pkt_cnt0 <= stat_pkt_cnt0 + CNT_ONE;
        end
        if (acc_s && sel_eop_s && sel_ch_s) begin
          stat_pkt_cnt1 <= stat_pkt_cnt1 + CNT_ONE;
        end
        // SOP on any beat but the opening one is flagged; the packet still flows.
        if (acc_s && sel_sop_s && !first_r) begin
          stat_sop_err <= 1'b1;
        end
      end
    end
  end

  // Output register: holds while stalled, empties when drained with no new beat.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      arb_out_valid         <= 1'b0;
      arb_out_data          <= '0;
      arb_out_startofpacket <= 1'b0;
      arb_out_endofpacket   <= 1'b0;
      arb_out_channel       <= 1'b0;
    end else if (load_s) begin
      arb_out_valid <= acc_s;
      if (acc_s) begin
        arb_out_data          <= sel_data_s;
        arb_out_startofpacket <= sel_sop_s;
        arb_out_endofpacket   <= sel_eop_s;
        arb_out_channel       <= sel_ch_s;
      end
    end
  end

endmodule
